// File: rtl/dma_engine.sv
// dma_engine: single-channel memory-to-memory DMA engine.
// A CPU config port exposes SRC, DST, LEN and CTRL registers. The engine moves
// LEN 32-bit words from SRC to DST over a valid/ready initiator port, one read
// beat followed by one write beat per word.
// Optional feature macro DMA_IRQ_EN: when defined, irq = done && irq_en;
// otherwise irq stays 0 and CTRL bit 2 ignores writes and reads back as 0.

module dma_engine #(
  parameter int LEN_BITS = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]          state;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LEN_BITS-1:0] len;
  logic [LEN_BITS-1:0] len_dec;
  logic                done;
  logic                irq_en;
  logic                abort_pend;
  logic [31:0]         buffer;
  logic [31:0]         reg_rdata;
  logic [1:0]          sel;
  logic                access;
  logic                wr;
  logic                ctrl_wr;
  logic                start_req;
  logic                clr_req;
  logic                abort_req;
  logic                abort_now;
  logic                busy;
  logic                beat;
  logic                unused_addr_bits;

  // Applies the byte-lane strobes of a CPU write onto an existing register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? val[i*8 +: 8] : cur[i*8 +: 8];
    end
    return res;
  endfunction

  // Upper address bits are decoded by the interconnect; low bits are byte offsets.
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  assign sel       = addr[3:2];
  assign access    = valid && !ready;
  assign wr        = access && (wstrb != 4'h0);
  assign ctrl_wr   = wr && (sel == 2'd3) && wstrb[0];
  assign start_req = ctrl_wr && wdata[0];
  assign clr_req   = ctrl_wr && wdata[1];
  assign abort_req = ctrl_wr && wdata[3];
  assign busy      = (state != IDLE);
  assign beat      = m_valid && m_ready;
  assign abort_now = abort_pend || abort_req;
  assign len_dec   = len - LEN_BITS'(1);
  assign m_wdata   = buffer;

`ifdef DMA_IRQ_EN
  assign irq = done && irq_en;
`else
  assign irq = 1'b0;
`endif

  // Register read mux; CTRL reports live busy plus the sticky done and irq_en bits.
  always_comb begin
    reg_rdata = 32'h0;
    case (sel)
      2'd0:    reg_rdata = src;
      2'd1:    reg_rdata = dst;
      2'd2:    reg_rdata = 32'(len);
      default: reg_rdata = {29'h0, irq_en, done, busy};
    endcase
  end

  // Config port: one-cycle ready pulse per access, read data captured alongside it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ready <= access;
      if (access) begin
        rdata <= reg_rdata;
      end
    end
  end

  // Register writes and the transfer FSM; bus outputs are registered so they hold during stalls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      src        <= 32'h0;
      dst        <= 32'h0;
      len        <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      abort_pend <= 1'b0;
      buffer     <= 32'h0;
      m_valid    <= 1'b0;
      m_addr     <= 32'h0;
      m_wstrb    <= 4'h0;
    end else begin
      if (wr && !busy) begin
        case (sel)
          2'd0:    src <= merge_bytes(src, wdata, wstrb) & ~32'h3;
          2'd1:    dst <= merge_bytes(dst, wdata, wstrb) & ~32'h3;
          2'd2:    len <= LEN_BITS'(merge_bytes(32'(len), wdata, wstrb));
          default: ;
        endcase
      end
`ifdef DMA_IRQ_EN
      if (ctrl_wr) begin
        irq_en <= wdata[2];
      end
`endif
      if (clr_req) begin
        done <= 1'b0;
      end
      if (abort_req && busy) begin
        abort_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            if ((len == '0) || abort_req) begin
              state <= FIN;
            end else begin
              state   <= RD;
              m_valid <= 1'b1;
              m_addr  <= src;
              m_wstrb <= 4'h0;
            end
          end
        end
        RD: begin
          if (beat) begin
            buffer <= m_rdata;
            if (abort_now) begin
              state   <= FIN;
              m_valid <= 1'b0;
            end else begin
              state   <= WR;
              m_addr  <= dst;
              m_wstrb <= 4'hF;
            end
          end
        end
        WR: begin
          if (beat) begin
            src     <= src + 32'd4;
            dst     <= dst + 32'd4;
            len     <= len_dec;
            m_wstrb <= 4'h0;
            if (abort_now || (len_dec == '0)) begin
              state   <= FIN;
              m_valid <= 1'b0;
            end else begin
              state  <= RD;
              m_addr <= src + 32'd4;
            end
          end
        end
        default: begin
          state      <= IDLE;
          done       <= 1'b1;
          abort_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule
